// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer definitions.
// Holds the ROB geometry and the per-entry record so that the register status
// table and the ROB agree on tag width.
package reorder_buffer_pkg;

    localparam int ROB_DEPTH  = 16;
    localparam int ROB_TAG_W  = 4;
    localparam int ROB_DATA_W = 32;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic [4:0]            dst;
        logic                  store;
        logic                  branch;
        logic                  mispredict;
        logic [ROB_DATA_W-1:0] data;
        logic [ROB_DATA_W-1:0] target;
    } rob_entry_s;

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer for the Tomasulo core.
//
// Ports:
//   clk_i, reset_ni              clock, async active-low reset
//   issue_*                      allocate an entry at the tail; tag = tail
//   cdb_*                        result writeback from the common data bus
//   rd_tag{1,2}_i / rd_*_o       operand lookup with same-cycle CDB forwarding
//   commit_*                     head retirement towards the register status table
//   recover_en_o, recover_pc_o   one-cycle flush pulse and redirect PC
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH  = ROB_DEPTH,
    parameter int TAG_W  = ROB_TAG_W,
    parameter int DATA_W = ROB_DATA_W
) (
    input  logic              clk_i,
    input  logic              reset_ni,

    input  logic              issue_valid_i,
    output logic              issue_ready_o,
    input  logic [4:0]        issue_dst_i,
    input  logic              issue_store_i,
    input  logic              issue_branch_i,
    output logic [TAG_W-1:0]  issue_tag_o,

    input  logic              cdb_valid_i,
    input  logic [TAG_W-1:0]  cdb_rob_tag_i,
    input  logic [DATA_W-1:0] cdb_data_i,
    input  logic              cdb_mispredict_i,
    input  logic [DATA_W-1:0] cdb_target_i,

    input  logic [TAG_W-1:0]  rd_tag1_i,
    input  logic [TAG_W-1:0]  rd_tag2_i,
    output logic              rd_ready1_o,
    output logic              rd_ready2_o,
    output logic [DATA_W-1:0] rd_data1_o,
    output logic [DATA_W-1:0] rd_data2_o,

    output logic              commit_valid_o,
    output logic [4:0]        commit_dst_o,
    output logic [TAG_W-1:0]  commit_rob_tag_o,
    output logic [DATA_W-1:0] commit_data_o,
    output logic              commit_store_o,

    output logic              recover_en_o,
    output logic [DATA_W-1:0] recover_pc_o
);

    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

    rob_entry_s        entry_q [DEPTH];
    rob_entry_s        entry_d [DEPTH];
    logic [TAG_W-1:0]  head_q, head_d;
    logic [TAG_W-1:0]  tail_q, tail_d;
    logic [TAG_W:0]    count_q, count_d;
    logic              rec_en_q, rec_en_d;
    logic [DATA_W-1:0] rec_pc_q, rec_pc_d;

    logic do_issue, do_cdb, do_commit, do_recover;
    rob_entry_s head_e;

    assign head_e = entry_q[head_q];

    // Readiness ignores a same-cycle commit so issue never depends on the
    // retire path combinationally.
    assign issue_ready_o = (count_q != FULL_CNT) && !rec_en_q;
    assign issue_tag_o   = tail_q;

    assign do_issue   = issue_valid_i && issue_ready_o;
    assign do_cdb     = cdb_valid_i && entry_q[cdb_rob_tag_i].valid && !rec_en_q;
    assign do_commit  = head_e.valid && head_e.done && !rec_en_q;
    assign do_recover = do_commit && head_e.branch && head_e.mispredict;

    assign commit_valid_o   = do_commit;
    assign commit_dst_o     = (head_e.store || head_e.branch) ? 5'd0 : head_e.dst;
    assign commit_rob_tag_o = head_q;
    assign commit_data_o    = head_e.data;
    assign commit_store_o   = head_e.store;

    assign recover_en_o = rec_en_q;
    assign recover_pc_o = rec_pc_q;

    // Lookups forward the CDB value so an operand produced this cycle is not
    // missed by an instruction issuing in the same cycle.
    always_comb begin
        rd_ready1_o = entry_q[rd_tag1_i].done;
        rd_data1_o  = entry_q[rd_tag1_i].data;
        if (cdb_valid_i && (cdb_rob_tag_i == rd_tag1_i)) begin
            rd_ready1_o = 1'b1;
            rd_data1_o  = cdb_data_i;
        end
        rd_ready2_o = entry_q[rd_tag2_i].done;
        rd_data2_o  = entry_q[rd_tag2_i].data;
        if (cdb_valid_i && (cdb_rob_tag_i == rd_tag2_i)) begin
            rd_ready2_o = 1'b1;
            rd_data2_o  = cdb_data_i;
        end
    end

    always_comb begin
        entry_d  = entry_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q + (TAG_W+1)'(do_issue) - (TAG_W+1)'(do_commit);
        rec_en_d = 1'b0;
        rec_pc_d = rec_pc_q;

        if (do_commit) begin
            entry_d[head_q].valid = 1'b0;
            head_d = head_q + TAG_W'(1);
        end

        if (do_cdb) begin
            entry_d[cdb_rob_tag_i].done       = 1'b1;
            entry_d[cdb_rob_tag_i].data       = cdb_data_i;
            entry_d[cdb_rob_tag_i].mispredict = cdb_mispredict_i;
            entry_d[cdb_rob_tag_i].target     = cdb_target_i;
        end

        if (do_issue) begin
            entry_d[tail_q] = '{valid: 1'b1, done: 1'b0, dst: issue_dst_i,
                                store: issue_store_i, branch: issue_branch_i,
                                mispredict: 1'b0, data: '0, target: '0};
            tail_d = tail_q + TAG_W'(1);
        end

        // A mispredicted branch retiring squashes everything younger; both
        // pointers restart just past the branch.
        if (do_recover) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_d[i] = '0;
            end
            head_d   = head_q + TAG_W'(1);
            tail_d   = head_q + TAG_W'(1);
            count_d  = '0;
            rec_en_d = 1'b1;
            rec_pc_d = head_e.target;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            rec_en_q <= 1'b0;
            rec_pc_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            rec_en_q <= rec_en_d;
            rec_pc_q <= rec_pc_d;
        end
    end

endmodule
